// File: rtl/dec_lut_encoder12bits_clk.sv
// Triangular-code encoder: W = N*(N+1)/2, computed with a shift-add multiplier
// that consumes one multiplier bit per clock. The result is held under a level 'found' flag.
module dec_lut_encoder12bits_clk #(
    parameter int N_BITS = 13,
    parameter int W_BITS = 25
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N_BITS-1:0] N,
    output logic              busy,
    output logic              found,
    output logic [W_BITS-1:0] W
);
    localparam int ACC_W = 2*N_BITS + 1;
    localparam int CNT_W = $clog2(N_BITS);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t            state, state_nxt;
    logic [N_BITS:0]   mcand;
    logic [N_BITS-1:0] mplier;
    logic [ACC_W-1:0]  acc, acc_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              last, accept;

    assign last   = (cnt == CNT_W'(N_BITS-1));
    assign accept = start && (state == IDLE || state == DONE);
    assign busy   = (state == MUL);
    assign found  = (state == DONE);

    // The final partial product must reach W on the same edge that leaves MUL.
    always_comb begin
        acc_nxt = acc;
        if (mplier[0])
            acc_nxt = acc + (ACC_W'(mcand) << cnt);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = MUL;
            MUL:     if (last)  state_nxt = DONE;
            DONE:    if (start) state_nxt = MUL;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            W      <= '0;
        end else if (accept) begin
            // One extra bit keeps N+1 exact at N = 2^N_BITS-1.
            mcand  <= {1'b0, N} + (N_BITS+1)'(1);
            mplier <= N;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == MUL) begin
            acc    <= acc_nxt;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (last)
                W <= W_BITS'(acc_nxt >> 1);
        end
    end
endmodule
